regfile_access_ctrl: RTL

Controller sitting between the datapath clients and the 32x32 `register_file`. It clears every register to zero after reset and shares the single write port between two requesters with round-robin arbitration. It drives both read ports on behalf of two read clients and forwards in-flight write data on read-after-write address matches, so clients never see stale data.

---
 rtl/regfile_access_ctrl_if.sv | 65 ++++++
 rtl/regfile_access_ctrl.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/regfile_access_ctrl_if.sv
// Client and register-file signal bundle for regfile_access_ctrl.
// slave = controller side, master = clients plus register file.
interface regfile_access_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) ();
  logic              wr_req_a;
  logic              wr_req_b;
  logic [ADDR_W-1:0] wr_addr_a;
  logic [ADDR_W-1:0] wr_addr_b;
  logic [DATA_W-1:0] wr_data_a;
  logic [DATA_W-1:0] wr_data_b;
  logic              wr_gnt_a;
  logic              wr_gnt_b;
  logic              rd_req_a;
  logic              rd_req_b;
  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic              rd_valid_a;
  logic              rd_valid_b;
  logic [DATA_W-1:0] rd_data_a;
  logic [DATA_W-1:0] rd_data_b;
  logic              busy;
  logic [DATA_W-1:0] rf_wd;
  logic [ADDR_W-1:0] rf_aw;
  logic [ADDR_W-1:0] rf_ar1;
  logic [ADDR_W-1:0] rf_ar2;
  logic              rf_rd;
  logic              rf_wr;
  logic              rf_en;
  logic [DATA_W-1:0] rf_rd1;
  logic [DATA_W-1:0] rf_rd2;

  modport slave (
    input  wr_req_a, wr_req_b,
    input  wr_addr_a, wr_addr_b,
    input  wr_data_a, wr_data_b,
    output wr_gnt_a, wr_gnt_b,
    input  rd_req_a, rd_req_b,
    input  rd_addr_a, rd_addr_b,
    output rd_valid_a, rd_valid_b,
    output rd_data_a, rd_data_b,
    output busy,
    output rf_wd, rf_aw,
    output rf_ar1, rf_ar2,
    output rf_rd, rf_wr, rf_en,
    input  rf_rd1, rf_rd2
  );

  modport master (
    output wr_req_a, wr_req_b,
    output wr_addr_a, wr_addr_b,
    output wr_data_a, wr_data_b,
    input  wr_gnt_a, wr_gnt_b,
    output rd_req_a, rd_req_b,
    output rd_addr_a, rd_addr_b,
    input  rd_valid_a, rd_valid_b,
    input  rd_data_a, rd_data_b,
    input  busy,
    input  rf_wd, rf_aw,
    input  rf_ar1, rf_ar2,
    input  rf_rd, rf_wr, rf_en,
    output rf_rd1, rf_rd2
  );
endinterface

// File: rtl/regfile_access_ctrl.sv
// Register file access controller: init sweep, round-robin
// write arbitration, dual read ports with write bypass.
module regfile_access_ctrl #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32
) (
  input logic                 clk,
  input logic                 rst,
  regfile_access_ctrl_if.slave bus
);

  typedef enum logic {
    S_CLEAR,
    S_RUN
  } state_t;

  localparam logic [ADDR_W:0] C_LAST =
    (ADDR_W+1)'(NUM_REGS - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W:0]   r_cnt;
  logic [ADDR_W:0]   w_cnt_nxt;
  logic              r_prio_b;
  logic              r_wr;
  logic [ADDR_W-1:0] r_aw;
  logic [DATA_W-1:0] r_wd;
  logic              r_rd;
  logic [ADDR_W-1:0] r_ar1;
  logic [ADDR_W-1:0] r_ar2;
  logic              r_rv1;
  logic              r_rv2;
  logic              r_valid_a;
  logic              r_valid_b;
  logic              r_byp_a;
  logic              r_byp_b;
  logic [DATA_W-1:0] r_bd_a;
  logic [DATA_W-1:0] r_bd_b;

  logic              w_clear;
  logic              w_run;
  logic              w_gnt_a;
  logic              w_gnt_b;
  logic              w_rf_wr;
  logic [ADDR_W-1:0] w_rf_aw;
  logic [DATA_W-1:0] w_rf_wd;
  logic              w_hit1;
  logic              w_hit2;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      S_CLEAR: begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt == C_LAST) w_state_nxt = S_RUN;
      end
      S_RUN:   w_state_nxt = S_RUN;
      default: w_state_nxt = S_CLEAR;
    endcase
  end

  assign w_clear = (r_state == S_CLEAR);
  assign w_run   = (r_state == S_RUN) & ~rst;

  // Pointer names the requester that wins a tie.
  assign w_gnt_a = w_run & bus.wr_req_a &
                   (~bus.wr_req_b | ~r_prio_b);
  assign w_gnt_b = w_run & bus.wr_req_b & ~w_gnt_a;

  assign w_rf_wr = ~rst & (w_clear | r_wr);
  assign w_rf_aw = w_clear ? r_cnt[ADDR_W-1:0] : r_aw;
  assign w_rf_wd = w_clear ? '0 : r_wd;

  assign w_hit1 = w_rf_wr & (w_rf_aw == r_ar1);
  assign w_hit2 = w_rf_wr & (w_rf_aw == r_ar2);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_CLEAR;
      r_cnt     <= '0;
      r_prio_b  <= 1'b0;
      r_wr      <= 1'b0;
      r_aw      <= '0;
      r_wd      <= '0;
      r_rd      <= 1'b0;
      r_ar1     <= '0;
      r_ar2     <= '0;
      r_rv1     <= 1'b0;
      r_rv2     <= 1'b0;
      r_valid_a <= 1'b0;
      r_valid_b <= 1'b0;
      r_byp_a   <= 1'b0;
      r_byp_b   <= 1'b0;
      r_bd_a    <= '0;
      r_bd_b    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_gnt_a)      r_prio_b <= 1'b1;
      else if (w_gnt_b) r_prio_b <= 1'b0;
      r_wr <= w_gnt_a | w_gnt_b;
      if (w_gnt_a) begin
        r_aw <= bus.wr_addr_a;
        r_wd <= bus.wr_data_a;
      end else if (w_gnt_b) begin
        r_aw <= bus.wr_addr_b;
        r_wd <= bus.wr_data_b;
      end
      r_rd  <= w_run & (bus.rd_req_a | bus.rd_req_b);
      r_rv1 <= w_run & bus.rd_req_a;
      r_rv2 <= w_run & bus.rd_req_b;
      if (w_run & bus.rd_req_a) r_ar1 <= bus.rd_addr_a;
      if (w_run & bus.rd_req_b) r_ar2 <= bus.rd_addr_b;
      r_valid_a <= r_rv1;
      r_valid_b <= r_rv2;
      // A write landing while the file is read returns stale data.
      r_byp_a <= r_rv1 & w_hit1;
      r_byp_b <= r_rv2 & w_hit2;
      if (r_rv1 & w_hit1) r_bd_a <= w_rf_wd;
      if (r_rv2 & w_hit2) r_bd_b <= w_rf_wd;
    end
  end

  assign bus.wr_gnt_a   = w_gnt_a;
  assign bus.wr_gnt_b   = w_gnt_b;
  assign bus.busy       = w_clear;
  assign bus.rf_wr      = w_rf_wr;
  assign bus.rf_aw      = w_rf_aw;
  assign bus.rf_wd      = w_rf_wd;
  assign bus.rf_ar1     = r_ar1;
  assign bus.rf_ar2     = r_ar2;
  assign bus.rf_rd      = r_rd;
  assign bus.rf_en      = ~rst;
  assign bus.rd_valid_a = r_valid_a;
  assign bus.rd_valid_b = r_valid_b;
  assign bus.rd_data_a  = ~r_valid_a ? '0 :
                          r_byp_a ? r_bd_a : bus.rf_rd1;
  assign bus.rd_data_b  = ~r_valid_b ? '0 :
                          r_byp_b ? r_bd_b : bus.rf_rd2;

endmodule
